// File: rtl/demux_pkg.sv
// Shared destination-code definitions for the 7-way select/distribute pair.
// Both the select mux and the write distributor use this one code table.
package demux_pkg;

    localparam int NDEST = 7;
    localparam int SEL_W = 3;

    typedef logic [SEL_W-1:0] dest_sel_t;

    localparam dest_sel_t SEL_ILLEGAL = 3'b111;

    function automatic logic sel_is_legal(input dest_sel_t sel);
        return (sel != SEL_ILLEGAL) && (int'(sel) < NDEST);
    endfunction

endpackage

// File: rtl/demux32_07_buf_hold_slot.sv
// Single-entry holding register with valid flag; loads on accept, drains on ack.
// A load in the same cycle as an ack wins, so one slot can be drained and refilled at once.
module hold_slot import demux_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic             ack_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ack_i) begin
            // The word stays visible after draining; only the flag drops.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/demux32_07_buf.sv
// One-to-seven word distributor: decodes the destination code, selects in_ready,
// and counts words dropped for an illegal code; storage lives in hold_slot.
module demux32_07_buf import demux_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int NDEST = demux_pkg::NDEST,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  dest_sel_t              signal,
    input  logic [WIDTH-1:0]       data_In,
    output logic [NDEST-1:0]       out_valid,
    input  logic [NDEST-1:0]       out_ack,
    output logic [NDEST*WIDTH-1:0] data_Out,
    output logic                   err_sel,
    output logic [CNT_W-1:0]       drop_cnt
);

    logic             legal;
    logic             ready_legal;
    logic             accept;
    logic             drop;
    logic [NDEST-1:0] hit;
    logic [NDEST-1:0] load;

    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        legal       = sel_is_legal(signal) && (int'(signal) < NDEST);
        hit         = '0;
        ready_legal = 1'b0;
        for (int i = 0; i < NDEST; i++) begin
            if (signal == SEL_W'(i)) begin
                hit[i]      = 1'b1;
                ready_legal = ~out_valid[i] | out_ack[i];
            end
        end
    end

    // Illegal codes are always sunk so a bad source can never stall the bus.
    assign in_ready = ~reset & (legal ? ready_legal : 1'b1);
    assign accept   = in_valid & in_ready;
    assign load     = hit & {NDEST{accept}};
    assign drop     = accept & ~legal;

    always_comb begin
        err_d = drop;
        cnt_d = cnt_q;
        if (drop && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign err_sel  = err_q;
    assign drop_cnt = cnt_q;

    for (genvar g = 0; g < NDEST; g++) begin : g_slot
        hold_slot #(.WIDTH(WIDTH)) u_slot (
            .clk_i   (clk),
            .reset_i (reset),
            .load_i  (load[g]),
            .ack_i   (out_ack[g]),
            .data_i  (data_In),
            .valid_o (out_valid[g]),
            .data_o  (data_Out[g*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_demux32_07_buf.sv
// Self-checking bench for demux32_07_buf: directed scenarios followed by random
// traffic, all checked against a per-channel behavioural model.
module tb_demux32_07_buf;

    localparam int W = 32;
    localparam int N = 7;
    localparam int C = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       signal;
    logic [W-1:0]     data_In;
    logic [N-1:0]     out_valid;
    logic [N-1:0]     out_ack;
    logic [N*W-1:0]   data_Out;
    logic             err_sel;
    logic [C-1:0]     drop_cnt;

    demux32_07_buf #(.WIDTH(W), .NDEST(N), .CNT_W(C)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .signal    (signal),
        .data_In   (data_In),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .data_Out  (data_Out),
        .err_sel   (err_sel),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: one flag and one word per destination, plus drop bookkeeping.
    bit          m_full [N];
    logic [31:0] m_word [N];
    int          m_drops;
    bit          m_err;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic bit model_ready(input bit rst, input int sel, input logic [N-1:0] ack);
        if (rst) return 1'b0;
        if (sel >= N) return 1'b1;
        return !m_full[sel] || ack[sel];
    endfunction

    task automatic check_outputs();
        for (int i = 0; i < N; i++) begin
            check_val($sformatf("out_valid[%0d]", i), {31'b0, out_valid[i]}, {31'b0, m_full[i]});
            check_val($sformatf("slice%0d", i), data_Out[i*W +: W], m_word[i]);
        end
        check_val("err_sel", {31'b0, err_sel}, {31'b0, m_err});
        check_val("drop_cnt", {24'b0, drop_cnt}, m_drops);
    endtask

    // One clock: drive, check in_ready before the edge, advance model, check state after.
    task automatic step(input bit v, input int sel, input logic [31:0] d,
                        input logic [N-1:0] ack, input bit rst);
        bit exp_rdy;
        reset    = rst;
        in_valid = v;
        signal   = sel[2:0];
        data_In  = d;
        out_ack  = ack;
        #2;
        exp_rdy = model_ready(rst, sel, ack);
        check_val("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_full[i] = 1'b0;
                m_word[i] = '0;
            end
            m_drops = 0;
            m_err   = 1'b0;
        end else begin
            m_err = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (ack[i] && m_full[i]) m_full[i] = 1'b0;
            end
            if (v && exp_rdy) begin
                if (sel < N) begin
                    m_full[sel] = 1'b1;
                    m_word[sel] = d;
                end else begin
                    m_err   = 1'b1;
                    m_drops = (m_drops < 255) ? m_drops + 1 : 255;
                end
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 0, 32'h0, '0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 0, 32'h0, '0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            m_full[i] = 1'b0;
            m_word[i] = '0;
        end
        m_drops = 0;
        m_err   = 1'b0;

        // Basic route to channel 2.
        do_reset();
        step(1'b1, 2, 32'hDEADBEEF, '0, 1'b0);
        check_val("route_valid", {25'b0, out_valid}, 32'h04);
        check_val("route_slice2", data_Out[2*W +: W], 32'hDEADBEEF);
        idle();

        // Full channel blocks, then drain+refill in the same cycle.
        do_reset();
        step(1'b1, 5, 32'h1, '0, 1'b0);
        step(1'b1, 5, 32'h2, '0, 1'b0);
        step(1'b1, 5, 32'h2, 7'h20, 1'b0);
        check_val("refill_slice5", data_Out[5*W +: W], 32'h2);
        idle();

        // Fill every channel, then an extra offer must stall.
        do_reset();
        for (int i = 0; i < N; i++) step(1'b1, i, 32'hA000_0000 + i, '0, 1'b0);
        check_val("all_full", {25'b0, out_valid}, 32'h7F);
        step(1'b1, 3, 32'h3333, '0, 1'b0);

        // Illegal code: always accepted, counter saturates.
        for (int k = 0; k < 300; k++) step(1'b1, 7, $urandom, '0, 1'b0);
        check_val("drop_sat", {24'b0, drop_cnt}, 32'hFF);
        idle();

        // Ack on one channel and accept on another in the same cycle.
        do_reset();
        step(1'b1, 1, 32'h1111_1111, '0, 1'b0);
        step(1'b1, 4, 32'h4444_4444, 7'h02, 1'b0);
        check_val("ack_keep_slice1", data_Out[1*W +: W], 32'h1111_1111);

        // Reset while words are held and a word is being offered.
        do_reset();
        step(1'b1, 0, 32'h0A0A_0A0A, '0, 1'b0);
        step(1'b1, 6, 32'h0606_0606, '0, 1'b0);
        step(1'b1, 7, 32'h7777_7777, '0, 1'b0);
        step(1'b1, 2, 32'h2222_2222, '0, 1'b1);
        check_val("post_reset_valid", {25'b0, out_valid}, 32'h0);
        idle();

        // Random traffic with occasional resets.
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom,
                 N'($urandom), ($urandom_range(0, 59) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux32_07_buf.md
Name: demux32_07_buf

Overview:
- One-to-seven 32-bit write distributor: the inverse of the 7-way datapath select.
- Accepts one word plus a 3-bit destination code per handshake and routes it into one of seven single-entry output holding registers.
- Each destination drains its word independently through its own valid/ack pair.
- Sits between a shared result source (ALU/memory return) and multiple datapath consumers that take data at different cycles.

Parameters:
- WIDTH, 32, data word width.
- NDEST, 7, number of destinations; select codes 0..NDEST-1 valid, all others illegal.
- CNT_W, 8, width of the illegal-select drop counter (saturating).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset; the block's only clock is clk.
- in_valid  in  1  source offers a word this cycle.
- in_ready  out  1  block accepts the offered word this cycle.
- signal  in  3  destination code (000..110 legal; 111 illegal).
- data_In  in  WIDTH  word to route.
- out_valid  out  NDEST  bit i: holding register i contains an undelivered word.
- out_ack  in  NDEST  bit i: consumer i takes its word this cycle; ignored when out_valid[i]=0.
- data_Out  out  NDEST*WIDTH  slice i at [i*WIDTH +: WIDTH] is holding register i.
- err_sel  out  1  one-cycle pulse when a word with an illegal code is accepted and dropped.
- drop_cnt  out  CNT_W  count of dropped words; saturates at all-ones.

Behaviour:
- Reset (synchronous; overrides all other activity in that cycle):
  - out_valid=0, data_Out=0, err_sel=0, drop_cnt=0.
  - Words held mid-operation are discarded.
  - in_ready is low in any cycle where reset=1.
- Accept condition: transfer occurs when in_valid & in_ready at a rising edge.
- in_ready (combinational from current state, signal, out_ack):
  - Legal code d: in_ready = ~out_valid[d] | out_ack[d]. Same-cycle drain and refill of one channel is allowed.
  - Illegal code: in_ready=1; the word is always sunk.
- On a legal accept to d:
  - Holding register d <= data_In and out_valid[d] <= 1, visible the next cycle (latency 1).
  - Other channels are unaffected except by their own acks.
- On an ack of channel i with no refill of i:
  - out_valid[i] <= 0.
  - data_Out slice i keeps its last value; it is not cleared.
- Simultaneous ack of i and accept into j≠i: both take effect in the same cycle.
- Illegal accept:
  - No holding register changes.
  - err_sel=1 for exactly the next cycle.
  - drop_cnt increments by 1 unless it is already all-ones (stays all-ones).
- Per-channel state machine, EMPTY/FULL (equal to out_valid[i]):
  - EMPTY→FULL on accept.
  - FULL→EMPTY on ack without accept.
  - FULL→FULL on ack with accept, which loads the new word; or with no ack, which holds.
- in_valid without in_ready: the source must hold data_In and signal stable. The block does not check this.
- data_In, signal and out_ack are not registered; there is no combinational path from data_In to data_Out.
- No throughput loss: one word per cycle is sustained when consumers ack immediately.

Decomposition:
- Shared package demux_pkg holds:
  - constants NDEST=7, SEL_W=3, SEL_ILLEGAL=3'b111;
  - a typedef for the destination code.
  - The 3-bit code table is shared with the 7-way select mux so both ends use identical encodings.
- One natural sub-module: hold_slot (one WIDTH-bit register + valid bit + load/ack logic), instantiated NDEST times in a generate loop.
- The top level contains only the decode, the in_ready selection and the drop counter.

Test Plan:
- Reset, then in_valid=1, signal=3'b010, data_In=32'hDEADBEEF.
  - Next cycle: out_valid=7'b0000100 and slice 2=DEADBEEF.
  - All other slices remain 0.
- Fill channel 5 with 32'h1, then offer 32'h2 to channel 5 with out_ack=0.
  - in_ready=0 and the word is held.
  - Then assert out_ack[5]=1: in_ready=1 that cycle, slice 5=32'h2 next cycle, out_valid[5] stays 1.
- Send to codes 0..6 on 7 consecutive cycles with out_ack all 0.
  - out_valid=7'h7F and each slice equals its sent value.
  - An 8th offer to code 3: in_ready=0.
- signal=3'b111 accepted 300 times.
  - err_sel pulses each time, out_valid unchanged.
  - drop_cnt ends at 8'hFF (saturated).
- Channel 1 full; in one cycle: out_ack[1]=1 and an accept to channel 4.
  - Next cycle: out_valid[1]=0, out_valid[4]=1.
  - Slice 1 keeps its old value.
- Channels 0 and 6 full; assert reset for one cycle while in_valid=1.
  - in_ready=0 during reset.
  - Afterward all outputs are 0 and drop_cnt=0.
